// File: rtl/dm_access_ctrl_if.sv
// Signal bundle between the MEM stage, the data-memory access sequencer and the memory bus.
// The slave view belongs to the sequencer. The master view belongs to whatever drives it.
interface dm_access_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  dmop;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        exc;
  logic [4:0]  exc_code;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, dmop, addr, wdata, mem_ack, mem_rdata,
    output stall, rdata, rdata_valid, exc, exc_code,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, dmop, addr, wdata, mem_ack, mem_rdata,
    input  stall, rdata, rdata_valid, exc, exc_code,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/dm_access_ctrl.sv
// MEM-stage data-memory sequencer. It turns one load or store into a byte-enabled bus cycle,
// stalls the pipeline until the cycle completes, and reports alignment and timeout faults.
module dm_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  dm_access_ctrl_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  dmop_q, dmop_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        exc_q, exc_d;
  logic [4:0]  exc_code_q, exc_code_d;

  logic        is_word, is_half, valid_op, misalign, fault;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // Decode of the access being presented, used only at acceptance
  always_comb begin
    is_word  = (bus.dmop == 3'd4);
    is_half  = (bus.dmop == 3'd2) || (bus.dmop == 3'd3);
    valid_op = bus.req_we ? ((bus.dmop == 3'd0) || (bus.dmop == 3'd2) || (bus.dmop == 3'd4))
                          : (bus.dmop <= 3'd4);
    misalign = (is_half && bus.addr[0]) || (is_word && (bus.addr[1:0] != 2'b00));
    fault    = !valid_op || misalign;
    if (is_word) begin
      be_new    = 4'b1111;
      wdata_new = bus.wdata;
    end else if (is_half) begin
      be_new    = bus.addr[1] ? 4'b1100 : 4'b0011;
      wdata_new = {2{bus.wdata[15:0]}};
    end else begin
      be_new    = 4'b0001 << bus.addr[1:0];
      wdata_new = {4{bus.wdata[7:0]}};
    end
  end

  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = bus.mem_rdata[7:0];
      2'd1:    byte_sel = bus.mem_rdata[15:8];
      2'd2:    byte_sel = bus.mem_rdata[23:16];
      default: byte_sel = bus.mem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (dmop_q)
      3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'd1:    load_ext = {24'd0, byte_sel};
      3'd2:    load_ext = {{16{half_sel[15]}}, half_sel};
      3'd3:    load_ext = {16'd0, half_sel};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    dmop_d        = dmop_q;
    lane_d        = lane_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    exc_d         = exc_q;
    exc_code_d    = exc_code_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d   = bus.req_we;
          dmop_d = bus.dmop;
          lane_d = bus.addr[1:0];
          if (fault) begin
            state_d       = RESP;
            rdata_valid_d = 1'b1;
            rdata_d       = 32'd0;
            exc_d         = 1'b1;
            exc_code_d    = bus.req_we ? 5'd5 : 5'd4;
          end else begin
            state_d     = BUSY;
            cnt_d       = 8'd0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_we;
            mem_addr_d  = {bus.addr[31:2], 2'b00};
            mem_be_d    = be_new;
            mem_wdata_d = wdata_new;
          end
        end
      end
      BUSY: begin
        // An ack on the last allowed cycle still completes the access normally
        if (bus.mem_ack) begin
          state_d       = RESP;
          mem_req_d     = 1'b0;
          rdata_valid_d = 1'b1;
          rdata_d       = we_q ? 32'd0 : load_ext;
          exc_d         = 1'b0;
          exc_code_d    = 5'd0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d       = RESP;
          mem_req_d     = 1'b0;
          rdata_valid_d = 1'b1;
          rdata_d       = 32'd0;
          exc_d         = 1'b1;
          exc_code_d    = 5'd7;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      dmop_q        <= 3'd0;
      lane_q        <= 2'd0;
      cnt_q         <= 8'd0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_be_q      <= 4'd0;
      mem_wdata_q   <= 32'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      exc_q         <= 1'b0;
      exc_code_q    <= 5'd0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      dmop_q        <= dmop_d;
      lane_q        <= lane_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      exc_q         <= exc_d;
      exc_code_q    <= exc_code_d;
    end
  end

  assign bus.stall       = bus.req_valid && (state_q != RESP);
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.exc         = exc_q;
  assign bus.exc_code    = exc_code_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_be      = mem_be_q;
  assign bus.mem_wdata   = mem_wdata_q;
endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Sequencer for the MEM-stage data-memory port. It accepts one load or store per handshake from the pipeline and turns it into a word-aligned, byte-enabled request on a variable-latency memory bus. It stalls the pipeline until the access completes, sign- or zero-extends load data, and raises address-error and bus-timeout exceptions. It sits between the MEM pipeline register and the data memory or bus bridge.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles `mem_req` may stay high without `mem_ack` before the access is aborted (range 1–255).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  the MEM stage presents an access.
- req_we  in  1  1 = store, 0 = load.
- dmop  in  3  access type. Loads: 0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw. Stores: 0 sb, 2 sh, 4 sw. Every other code is invalid.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- stall  out  1  freeze the pipeline.
- rdata  out  32  extended load result.
- rdata_valid  out  1  the result or exception is valid this cycle.
- exc  out  1  the access faulted.
- exc_code  out  5  4 AdEL, 5 AdES, 7 DBE (timeout).
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  32  `{addr[31:2],2'b00}`.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  bus completion.
- mem_rdata  in  32  bus read word.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**, `req_valid` = 1:
  - Latch `req_we`, `dmop`, `addr`, `wdata`.
  - Misaligned or invalid access goes to RESP with `exc` = 1 and no bus cycle. Misaligned means lh/lhu/sh with `addr[0]` = 1, or lw/sw with `addr[1:0]` ≠ 0. Invalid means a dmop outside the tables above; stores with dmop 1 or 3 are invalid.
  - `exc_code` = 4 if `req_we` = 0, else 5.
  - Otherwise go to BUSY.
- **BUSY**:
  - `mem_req` = 1, with `mem_we`/`mem_addr`/`mem_be`/`mem_wdata` driven from latched fields and held constant.
  - `mem_ack` = 1: capture the extended load data (stores capture 0), then go to RESP.
  - Timeout counter reaches TIMEOUT with no ack: go to RESP with `exc` = 1, `exc_code` = 7.
- **RESP**: `rdata_valid` = 1 for exactly one cycle, then IDLE.
- Byte enables:
  - Byte access: `4'b0001 << addr[1:0]`.
  - Half access: `addr[1]` ? `1100` : `0011`.
  - Word access: `1111`.
  - Loads drive the same enables as stores.
- Store data:
  - sb: `{4{wdata[7:0]}}`.
  - sh: `{2{wdata[15:0]}}`.
  - sw: `wdata`.
- Load extension, selecting the lane by `addr[1:0]`:
  - lb: sign-extend the selected byte.
  - lbu: zero-extend the selected byte.
  - lh/lhu: sign/zero-extend the selected halfword (`addr[1]` picks the upper half).
  - lw: the word unchanged.
- `stall` = `req_valid` && state ≠ RESP (combinational). The pipeline advances on the RESP cycle.
- `mem_ack` outside BUSY is ignored.
- Input changes after acceptance are ignored; the latched copy governs.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE.
  - `mem_req` = 0, `mem_we` = 0, `mem_be` = 0, `mem_addr` = 0, `mem_wdata` = 0.
  - `rdata` = 0, `rdata_valid` = 0, `exc` = 0, `exc_code` = 0.
  - Timeout counter cleared.
  - Reset mid-BUSY drops `mem_req` at once, and a later `mem_ack` is ignored.
- All bus outputs are registered. `mem_req` rises the cycle after acceptance.
- Successful access, request seen in cycle 0:
  - `mem_req` high from cycle 1.
  - Ack in cycle k ≥ 1 gives RESP in cycle k+1.
  - Minimum latency is 2 cycles; back-to-back accesses take 3 cycles each.
- Faulted alignment check: RESP in cycle 1, and `mem_req` never rises.
- Timeout:
  - The counter increments on every BUSY cycle without ack.
  - If ack has not arrived after TIMEOUT cycles of `mem_req`, `mem_req` falls and RESP follows in the next cycle.
  - Ack and the final timeout cycle together: the ack wins and no exception is raised.
- `rdata`, `exc` and `exc_code` hold their value until the next RESP. `exc` and `exc_code` are qualified by `rdata_valid`.
- A new request presented during RESP is not accepted until the following IDLE cycle.

## Test plan
- **lb**: `addr` = 0x1003, `mem_rdata` = 0x80FF_0000, ack on the first request cycle → `mem_be` = 1000, `mem_addr` = 0x1000. RESP in cycle 2 with `rdata` = 0xFFFF_FF80, `stall` 1,1,0.
- **lhu**: `addr` = 0x2002, `mem_rdata` = 0xBEEF_1234, ack after 3 wait cycles → `rdata` = 0x0000_BEEF, `mem_be` = 1100.
- **sb/sh**: sb `addr` = 0x11, `wdata` = 0x0000_00A5 → `mem_be` = 0010, `mem_wdata` = 0xA5A5_A5A5, `mem_we` = 1. sh `addr` = 0x12 → `mem_be` = 1100.
- **Misaligned**: lw at 0x6 → `exc` = 1, `exc_code` = 4 in cycle 1, `mem_req` stays 0. sh at 0x3 → `exc_code` = 5.
- **Timeout**: TIMEOUT = 4, no ack → `mem_req` high exactly 4 cycles, then RESP with `exc_code` = 7. Repeat with ack on the 4th cycle → no exception.
- **Reset mid-access**: `reset` low during BUSY → `mem_req` = 0 immediately. After release, a late `mem_ack` produces no `rdata_valid`, and a new lw completes normally.
